// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a shared IF/MEM memory-port arbiter; grants are registered, stall is combinational.
// Optional saturating perf counters (stall_cycles, flush_count) are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic        mem_req,
   input  logic        port_done,
   input  logic        stallreq_id,
   input  logic        branch_taken,
   output logic        if_grant,
   output logic        mem_grant,
   output logic        if_discard,
   output logic [6:0]  stall,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IF_BUSY  = 2'd1,
      MEM_BUSY = 2'd2
   } state_t;

   localparam logic [6:0] STALL_MEM    = 7'b0011111;
   localparam logic [6:0] STALL_FLUSH  = 7'b1100000;
   localparam logic [6:0] STALL_LOADUSE = 7'b0000011;
   localparam logic [6:0] STALL_FETCH  = 7'b0000001;

   state_t state_q, state_d;
   logic   discard_q, discard_d;

   logic fetch_done;
   logic mem_done;
   logic mem_wait;
   logic if_wait;
   logic branch_acc;

   // A completing access no longer counts as waiting in its done cycle.
   always_comb begin
      fetch_done = (state_q == IF_BUSY)  && port_done;
      mem_done   = (state_q == MEM_BUSY) && port_done;
      mem_wait   = mem_req && !mem_done;
      if_wait    = if_req  && !fetch_done;
      branch_acc = branch_taken && !mem_wait;
   end

   always_comb begin
      state_d    = state_q;
      discard_d  = discard_q;
      if_grant   = (state_q == IF_BUSY);
      mem_grant  = (state_q == MEM_BUSY);
      if_discard = fetch_done && (discard_q || branch_acc);
      stall      = 7'b0000000;

      if (mem_wait) begin
         stall = STALL_MEM;
      end else if (branch_taken) begin
         stall = STALL_FLUSH;
      end else if (stallreq_id) begin
         stall = STALL_LOADUSE;
      end else if (if_wait) begin
         stall = STALL_FETCH;
      end

      // A flush that lands while a fetch is still in flight marks that fetch stale.
      if (fetch_done) begin
         discard_d = 1'b0;
      end else if ((state_q == IF_BUSY) && branch_acc) begin
         discard_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (mem_req) begin
               state_d = MEM_BUSY;
            end else if (if_req) begin
               state_d = IF_BUSY;
            end
         end
         IF_BUSY: begin
            if (port_done) begin
               state_d = mem_req ? MEM_BUSY : IDLE;
            end
         end
         MEM_BUSY: begin
            if (port_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if ((stall[4:0] != 5'b00000) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (branch_acc && (flush_count_q != 32'hFFFF_FFFF)) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, reset corner sequence, then random traffic against a reference model.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic        mem_req;
   logic        port_done;
   logic        stallreq_id;
   logic        branch_taken;
   logic        if_grant;
   logic        mem_grant;
   logic        if_discard;
   logic [6:0]  stall;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   int tests_run = 0;
   int tests_failed = 0;

   pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .if_req       (if_req),
      .mem_req      (mem_req),
      .port_done    (port_done),
      .stallreq_id  (stallreq_id),
      .branch_taken (branch_taken),
      .if_grant     (if_grant),
      .mem_grant    (mem_grant),
      .if_discard   (if_discard),
      .stall        (stall),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: who owns the port (0 none, 1 fetch, 2 mem), whether the
   // in-flight fetch went stale, and running event counts.
   int     m_owner;
   bit     m_stale;
   longint m_sc;
   longint m_fc;

   logic       e_ig, e_mg, e_dis, e_br;
   logic [6:0] e_st;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_eval();
      bit fetch_ends, mem_ends, mem_stalls, if_stalls;
      fetch_ends = (m_owner == 1) && port_done;
      mem_ends   = (m_owner == 2) && port_done;
      mem_stalls = mem_req && !mem_ends;
      if_stalls  = if_req && !fetch_ends;
      e_br  = branch_taken && !mem_stalls;
      e_ig  = (m_owner == 1);
      e_mg  = (m_owner == 2);
      e_dis = fetch_ends && (m_stale || e_br);
      if (mem_stalls)       e_st = 7'b0011111;
      else if (branch_taken) e_st = 7'b1100000;
      else if (stallreq_id) e_st = 7'b0000011;
      else if (if_stalls)   e_st = 7'b0000001;
      else                  e_st = 7'b0000000;
   endtask

   task automatic model_update();
      if (rst) begin
         m_owner = 0;
         m_stale = 0;
         m_sc    = 0;
         m_fc    = 0;
      end else begin
         if (e_st[4:0] != 5'b0 && m_sc < 64'hFFFF_FFFF) m_sc++;
         if (e_br && m_fc < 64'hFFFF_FFFF) m_fc++;
         if ((m_owner == 1) && port_done) m_stale = 0;
         else if ((m_owner == 1) && e_br) m_stale = 1;
         case (m_owner)
            0: m_owner = mem_req ? 2 : (if_req ? 1 : 0);
            1: if (port_done) m_owner = mem_req ? 2 : 0;
            default: if (port_done) m_owner = 0;
         endcase
      end
   endtask

   task automatic step(input logic ir, input logic mr, input logic pd,
                       input logic sid, input logic bt, input logic r);
      @(negedge clk);
      if_req       = ir;
      mem_req      = mr;
      port_done    = pd;
      stallreq_id  = sid;
      branch_taken = bt;
      rst          = r;
      #2;
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   task automatic chk_counters(input string tag);
`ifdef PIPE_CTRL_PERF_EN
      chk({tag, " stall_cycles"}, stall_cycles, m_sc[31:0]);
      chk({tag, " flush_count"}, flush_count, m_fc[31:0]);
`else
      chk({tag, " stall_cycles"}, stall_cycles, 32'd0);
      chk({tag, " flush_count"}, flush_count, 32'd0);
`endif
   endtask

   typedef struct {
      logic       ir, mr, pd, sid, bt;
      logic       ig, mg, dis;
      logic [6:0] st;
   } vec_t;

   function automatic vec_t mk(input logic ir, input logic mr, input logic pd, input logic sid,
                               input logic bt, input logic ig, input logic mg, input logic dis,
                               input logic [6:0] st);
      vec_t v;
      v.ir = ir; v.mr = mr; v.pd = pd; v.sid = sid; v.bt = bt;
      v.ig = ig; v.mg = mg; v.dis = dis; v.st = st;
      return v;
   endfunction

   initial begin
      vec_t vecs[$];
      string tag;

      //              ir mr pd id bt   ig mg ds  stall
      // reset state, then fetch with done three cycles later
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 1, 0, 0,  1, 0, 0, 7'b0000000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // simultaneous requests: MEM first, one IDLE cycle, then fetch
      vecs.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 7'b0011111));
      vecs.push_back(mk(1, 1, 0, 0, 0,  0, 1, 0, 7'b0011111));
      vecs.push_back(mk(1, 1, 1, 0, 0,  0, 1, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 1, 0, 0,  1, 0, 0, 7'b0000000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // branch during fetch, done two cycles later drops the stale fetch
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 0, 0, 1,  1, 0, 0, 7'b1100000));
      vecs.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 1, 0, 0,  1, 0, 1, 7'b0000000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // branch held by frozen EX during mem_wait, accepted once it drops
      vecs.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0, 7'b0011111));
      vecs.push_back(mk(0, 1, 0, 0, 1,  0, 1, 0, 7'b0011111));
      vecs.push_back(mk(0, 1, 1, 0, 1,  0, 1, 0, 7'b1100000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // load-use hazard beats fetch wait
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, 0, 0, 7'b0000011));
      vecs.push_back(mk(1, 0, 0, 1, 0,  0, 0, 0, 7'b0000011));
      vecs.push_back(mk(1, 0, 0, 1, 0,  1, 0, 0, 7'b0000011));
      vecs.push_back(mk(1, 0, 1, 0, 0,  1, 0, 0, 7'b0000000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // branch in the very cycle the fetch completes
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 0, 1, 0, 1,  1, 0, 1, 7'b1100000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // stray done in IDLE is ignored
      vecs.push_back(mk(0, 0, 1, 0, 0,  0, 0, 0, 7'b0000000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));
      // fetch completes with MEM pending: straight hand-over to MEM
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 7'b0000001));
      vecs.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 7'b0011111));
      vecs.push_back(mk(0, 1, 1, 0, 0,  1, 0, 0, 7'b0011111));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0, 1, 0, 7'b0011111));
      vecs.push_back(mk(0, 1, 1, 0, 0,  0, 1, 0, 7'b0000000));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, 7'b0000000));

      m_owner = 0; m_stale = 0; m_sc = 0; m_fc = 0;
      rst = 1'b1; if_req = 0; mem_req = 0; port_done = 0; stallreq_id = 0; branch_taken = 0;
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 0, 1);
         tick();
      end

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].ir, vecs[i].mr, vecs[i].pd, vecs[i].sid, vecs[i].bt, 0);
         tag = $sformatf("vec%0d", i);
         chk({tag, " if_grant"}, {31'd0, if_grant}, {31'd0, vecs[i].ig});
         chk({tag, " mem_grant"}, {31'd0, mem_grant}, {31'd0, vecs[i].mg});
         chk({tag, " if_discard"}, {31'd0, if_discard}, {31'd0, vecs[i].dis});
         chk({tag, " stall"}, {25'd0, stall}, {25'd0, vecs[i].st});
         chk_counters(tag);
         tick();
      end

      // Reset in the middle of a MEM access, followed by a stray done.
      step(0, 1, 0, 0, 0, 0);
      tick();
      step(0, 1, 0, 0, 0, 0);
      chk("rstseq busy mem_grant", {31'd0, mem_grant}, 32'd1);
      tick();
      step(0, 0, 0, 0, 0, 1);
      tick();
      step(0, 0, 1, 0, 0, 0);
      chk("rstseq stray if_grant", {31'd0, if_grant}, 32'd0);
      chk("rstseq stray mem_grant", {31'd0, mem_grant}, 32'd0);
      chk("rstseq stray stall", {25'd0, stall}, 32'd0);
      chk("rstseq stall_cycles", stall_cycles, 32'd0);
      chk("rstseq flush_count", flush_count, 32'd0);
      tick();
      step(0, 0, 0, 0, 0, 0);
      chk("rstseq after mem_grant", {31'd0, mem_grant}, 32'd0);
      chk("rstseq after if_grant", {31'd0, if_grant}, 32'd0);
      tick();

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(1, 0) == 1, $urandom_range(3, 0) == 0, $urandom_range(9, 0) < 3,
              $urandom_range(4, 0) == 0, $urandom_range(6, 0) == 0, $urandom_range(149, 0) == 0);
         tag = $sformatf("rnd%0d", i);
         chk({tag, " if_grant"}, {31'd0, if_grant}, {31'd0, e_ig});
         chk({tag, " mem_grant"}, {31'd0, mem_grant}, {31'd0, e_mg});
         chk({tag, " if_discard"}, {31'd0, if_discard}, {31'd0, e_dis});
         chk({tag, " stall"}, {25'd0, stall}, {25'd0, e_st});
         chk_counters(tag);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
